// File: rtl/alu_issue_queue_if.sv
// Handshake bundle for the ALU issue queue: the command input, the ALU
// operand/result path, the result slot and the sticky status path.
// slave is the queue itself; master is whatever surrounds it.
interface alu_issue_queue_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(DEPTH+1)
);
   // command input
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       in_opcode;
   // combinational ALU hookup
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_opcode;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ov;
   // result slot
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_ov;
   logic [3:0]       out_opcode;
   logic             out_illegal;
   // status
   logic             sticky_ov;
   logic             clr_sticky;
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid, in_a, in_b, in_opcode,
      output in_ready,
      output alu_a, alu_b, alu_opcode,
      input  alu_result, alu_ov,
      output out_valid, out_result, out_ov, out_opcode, out_illegal,
      input  out_ready,
      output sticky_ov, count,
      input  clr_sticky
   );

   modport master (
      output in_valid, in_a, in_b, in_opcode,
      input  in_ready,
      input  alu_a, alu_b, alu_opcode,
      output alu_result, alu_ov,
      input  out_valid, out_result, out_ov, out_opcode, out_illegal,
      output out_ready,
      input  sticky_ov, count,
      output clr_sticky
   );
endinterface

// File: rtl/alu_issue_queue.sv
// Buffered issue stage in front of the 16-bit opcode ALU. Commands queue in
// a DEPTH-entry FIFO; the head is shown to the combinational ALU and its
// answer is captured into a single output slot with its own handshake.
// Opcodes 10..15 are illegal: they are consumed but produce a zero result.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input logic clk,
   input logic rst,
   alu_issue_queue_if.slave q
);
   localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
   localparam logic [3:0]       OP_ILL = 4'd10;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [3:0]       op;
   } cmd_t;

   cmd_t             mem [DEPTH];
   cmd_t             in_cmd;
   cmd_t             head_cmd;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic             empty;
   logic             in_ready;
   logic             push;
   logic             pop;
   logic             slot_free;
   logic             illegal;

   logic             out_valid;
   logic [WIDTH-1:0] out_result;
   logic             out_ov;
   logic [3:0]       out_opcode;
   logic             out_illegal;
   logic             sticky_ov;

   // ---------------------------------------------------------------
   // handshake decode; in_ready looks only at registered occupancy so
   // a full queue never accepts, even when the head pops this cycle
   // ---------------------------------------------------------------
   assign empty     = (count == '0);
   assign in_ready  = (count != FULL);
   assign push      = q.in_valid & in_ready;
   assign slot_free = !out_valid | q.out_ready;
   assign pop       = !empty & slot_free;

   assign in_cmd    = '{a: q.in_a, b: q.in_b, op: q.in_opcode};
   assign head_cmd  = mem[head];
   assign illegal   = (head_cmd.op >= OP_ILL);

   // head entry to the ALU; forced to zero when nothing is queued
   assign q.alu_a      = empty ? '0 : head_cmd.a;
   assign q.alu_b      = empty ? '0 : head_cmd.b;
   assign q.alu_opcode = empty ? '0 : head_cmd.op;

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= in_cmd;
   end

   // pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + PTR_W'(1);
         if (pop)
            head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // result slot: load on pop, drop valid when drained with nothing behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_ov      <= 1'b0;
         out_opcode  <= '0;
         out_illegal <= 1'b0;
      end else if (pop) begin
         out_valid  <= 1'b1;
         out_opcode <= head_cmd.op;
         if (illegal) begin
            // ALU output is meaningless for these opcodes; do not sample it
            out_result  <= '0;
            out_ov      <= 1'b0;
            out_illegal <= 1'b1;
         end else begin
            out_result  <= q.alu_result;
            out_ov      <= q.alu_ov;
            out_illegal <= 1'b0;
         end
      end else if (out_valid && q.out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // sticky overflow; a capturing overflow beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sticky_ov <= 1'b0;
      else if (pop && !illegal && q.alu_ov)
         sticky_ov <= 1'b1;
      else if (q.clr_sticky)
         sticky_ov <= 1'b0;
   end

   assign q.in_ready    = in_ready;
   assign q.out_valid   = out_valid;
   assign q.out_result  = out_result;
   assign q.out_ov      = out_ov;
   assign q.out_opcode  = out_opcode;
   assign q.out_illegal = out_illegal;
   assign q.sticky_ov   = sticky_ov;
   assign q.count       = count;
endmodule
